ndp_result_drain: RTL and testbench
===================================

// Module: ndp_result_drain
// PURPOSE
//  Downstream stage of the NDP compute unit. Snapshots the full result matrix out_c when
//  calc_done_flag rises, then streams it row-major as fixed-width beats over a valid/ready
//  interface to the writeback path. Frees the compute unit to start the next tile while draining.
// PARAMETERS
//  WIDTH       16   element width (FP16: 1 sign, EXP_BITS=5, FRAC_BITS=10)
//  ROWS        4    result rows (= ARR_HEIGHT*SYS_HEIGHT)
//  COLS        256  result columns (= ARR_WIDTH*SYS_WIDTH)
//  BEAT_ELEMS  16   elements per output beat; COLS % BEAT_ELEMS == 0 required (elaboration error otherwise)
//  BEAT_AW     6    out_addr width; >= clog2(ROWS*COLS/BEAT_ELEMS)
// PORTS
//  clk             in   1                    clock
//  reset           in   1                    synchronous, active-high reset
//  calc_done_flag  in   1                    level from compute unit; rising edge = result valid
//  in_c            in   ROWS*COLS*WIDTH      result matrix; element (r,c) at bits [(r*COLS+c)*WIDTH +: WIDTH]
//  out_valid       out  1                    beat valid
//  out_ready       in   1                    sink accepts beat
//  out_data        out  BEAT_ELEMS*WIDTH     beat payload; element e at [e*WIDTH +: WIDTH]
//  out_addr        out  BEAT_AW              beat index 0..NBEATS-1, NBEATS=ROWS*COLS/BEAT_ELEMS
//  out_last        out  1                    high with final beat of the tile
//  busy            out  1                    high in DRAIN
//  drain_done      out  1                    one-cycle pulse after last beat accepted
//  overrun         out  1                    sticky: new done edge arrived while busy
// BEHAVIOUR
//  - Reset (sync, active-high): state IDLE; out_valid, out_last, busy, drain_done, overrun = 0;
//    out_addr = 0; beat counter = 0; done-edge history register = 0. Snapshot contents not cleared.
//  - Edge detect: edge = calc_done_flag & ~done_q; done_q registers calc_done_flag every cycle.
//  - FSM IDLE: on edge, capture in_c into snapshot register same cycle, beat counter = 0 -> DRAIN.
//  - FSM DRAIN: out_valid=1; out_data = snapshot elements [cnt*BEAT_ELEMS +: BEAT_ELEMS];
//    out_addr = cnt; out_last = (cnt == NBEATS-1). Handshake = out_valid & out_ready.
//    On handshake cnt++; on handshake with out_last -> DONE. First beat valid 1 cycle after edge.
//  - FSM DONE: drain_done=1 for exactly one cycle, out_valid=0 -> IDLE. Edge here is accepted
//    (captured, -> DRAIN next) only from IDLE; edge in DONE counts as overrun.
//  - Valid/ready rules: out_valid never drops and out_data/out_addr/out_last hold stable while
//    out_valid & ~out_ready. out_ready ignored when out_valid=0. Throughput 1 beat/cycle if ready held.
//  - Overrun: edge while state != IDLE (incl. cycle of final handshake) -> overrun<=1, snapshot
//    untouched, edge dropped. overrun clears only on reset.
//  - Level held high across tiles generates no new edge; calc_done_flag must fall then rise.
//  - Reset mid-DRAIN: out_valid drops next cycle, partial tile abandoned, no drain_done.
//  - No arithmetic on data except optional ReLU; counter wraps never (terminates at NBEATS-1).
// CONFIGURATION
//  NDP_DRAIN_RELU_EN defined: each element with sign bit set (bit WIDTH-1) replaced by 0 at
//    out_data mux (combinational, no added latency); -0.0 also -> +0.0; NaN with sign set -> 0.
//  Undefined: out_data carries snapshot elements bit-exact.
// STRUCTURE
//  - Package ndp_pkg: state encoding localparams (S_IDLE, S_DRAIN, S_DONE), NBEATS and
//    BEAT_BITS = BEAT_ELEMS*WIDTH derivations, FP16 sign-bit index constant.
//  - One sub-module: ndp_drain_beat_mux (snapshot + cnt -> beat slice, ReLU under macro).
//  - Top holds snapshot register, edge detect, FSM, beat counter, status flags.
// TESTING (defaults: NBEATS=64, 16 beats/row)
//  1 element(r,c)=r*256+c, done rises, out_ready=1 -> 64 consecutive beats, addr 0..63, beat 17
//    element 0 = 0x0110, out_last only on addr 63, drain_done pulse cycle after, busy low after.
//  2 out_ready random 30% -> data/addr stable during stalls, beat sequence identical to test 1.
//  3 second done edge at beat 20 with different in_c -> overrun=1, remaining beats from first
//    snapshot, no second drain; new edge after IDLE drains new tile, overrun stays 1.
//  4 calc_done_flag held high 200 cycles -> exactly one drain; fall+rise -> second drain.
//  5 reset at beat 30 -> out_valid=0 next cycle, no drain_done, all flags 0; next edge restarts addr 0.
//  6 NDP_DRAIN_RELU_EN, elements 0xBC00(-1.0), 0x8000, 0x3C00 -> 0x0000,0x0000,0x3C00; undefined -> unchanged.

Source files
------------

// File: rtl/ndp_result_drain_pkg.sv
// ndp_pkg: shared constants for the NDP result drain stage.
//   - FSM state encodings (S_IDLE, S_DRAIN, S_DONE)
//   - default geometry and derived NBEATS / BEAT_BITS values
//   - FP16 sign-bit index
// No ports (package).
package ndp_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_ROWS       = 4;
  localparam int unsigned DEF_COLS       = 256;
  localparam int unsigned DEF_BEAT_ELEMS = 16;
  localparam int unsigned DEF_BEAT_AW    = 6;

  localparam int unsigned FP16_SIGN_BIT  = 15;

  function automatic int unsigned calc_nbeats(input int unsigned rows,
                                              input int unsigned cols,
                                              input int unsigned beat_elems);
    return (rows * cols) / beat_elems;
  endfunction

  function automatic int unsigned calc_beat_bits(input int unsigned beat_elems,
                                                 input int unsigned width);
    return beat_elems * width;
  endfunction

  localparam int unsigned DEF_NBEATS    = calc_nbeats(DEF_ROWS, DEF_COLS, DEF_BEAT_ELEMS);
  localparam int unsigned DEF_BEAT_BITS = calc_beat_bits(DEF_BEAT_ELEMS, DEF_WIDTH);

endpackage

// File: rtl/ndp_result_drain_if.sv
// ndp_result_drain_if: valid/ready beat bus from the result drain to writeback.
//   out_valid  master->slave  beat valid
//   out_ready  slave->master  sink accepts beat
//   out_data   master->slave  BEAT_ELEMS*WIDTH payload, element e at [e*WIDTH +: WIDTH]
//   out_addr   master->slave  beat index
//   out_last   master->slave  final beat of the tile
interface ndp_result_drain_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned BEAT_ELEMS = 16,
  parameter int unsigned BEAT_AW    = 6
);
  logic                          out_valid;
  logic                          out_ready;
  logic [BEAT_ELEMS*WIDTH-1:0]   out_data;
  logic [BEAT_AW-1:0]            out_addr;
  logic                          out_last;

  modport master (output out_valid, output out_data, output out_addr,
                  output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_addr,
                  input out_last, output out_ready);
endinterface

// File: rtl/ndp_result_drain_beat_mux.sv
// ndp_drain_beat_mux: selects beat i_cnt out of the snapshot (row-major,
// BEAT_ELEMS consecutive elements per beat). Purely combinational.
// Optional feature macro: NDP_DRAIN_RELU_EN -- any element with its sign bit
// set is forced to +0 (covers -0.0 and negative NaN too).
// Ports:
//   i_snap  snapshot, NBEATS*BEAT_ELEMS*WIDTH bits
//   i_cnt   beat index
//   o_beat  selected beat payload
module ndp_drain_beat_mux
  import ndp_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned BEAT_ELEMS = DEF_BEAT_ELEMS,
  parameter int unsigned NBEATS     = DEF_NBEATS,
  parameter int unsigned CNT_W      = DEF_BEAT_AW
) (
  input  logic [NBEATS*BEAT_ELEMS*WIDTH-1:0] i_snap,
  input  logic [CNT_W-1:0]                   i_cnt,
  output logic [BEAT_ELEMS*WIDTH-1:0]        o_beat
);

  localparam int unsigned BEAT_BITS = calc_beat_bits(BEAT_ELEMS, WIDTH);

  logic [BEAT_BITS-1:0] w_raw;
  logic [31:0]          w_base;

  always_comb begin
    w_base = 32'(i_cnt) * BEAT_BITS;
    w_raw  = i_snap[w_base +: BEAT_BITS];
  end

`ifdef NDP_DRAIN_RELU_EN
  localparam int unsigned SIGN_BIT = (WIDTH == 16) ? FP16_SIGN_BIT : WIDTH - 1;

  always_comb begin
    o_beat = w_raw;
    for (int unsigned e = 0; e < BEAT_ELEMS; e++) begin
      if (w_raw[e*WIDTH + SIGN_BIT]) begin
        o_beat[e*WIDTH +: WIDTH] = '0;
      end
    end
  end
`else
  always_comb begin
    o_beat = w_raw;
  end
`endif

endmodule

// File: rtl/ndp_result_drain.sv
// ndp_result_drain: snapshots the compute unit's result matrix on a rising
// calc_done_flag and streams it row-major as fixed-width beats over a
// valid/ready bus, freeing the compute unit to start the next tile.
// Optional feature macro: NDP_DRAIN_RELU_EN (ReLU on output elements, see
// ndp_drain_beat_mux).
// Ports:
//   clk             clock
//   reset           synchronous active-high reset
//   calc_done_flag  level from compute unit; rising edge = result valid
//   in_c            result matrix, element (r,c) at [(r*COLS+c)*WIDTH +: WIDTH]
//   drn             beat bus (master side): out_valid/out_ready/out_data/out_addr/out_last
//   busy            high while draining
//   drain_done      one-cycle pulse after the last beat is accepted
//   overrun         sticky: a done edge arrived while not idle
module ndp_result_drain
  import ndp_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned BEAT_ELEMS = DEF_BEAT_ELEMS,
  parameter int unsigned BEAT_AW    = DEF_BEAT_AW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       calc_done_flag,
  input  logic [ROWS*COLS*WIDTH-1:0] in_c,
  ndp_result_drain_if.master         drn,
  output logic                       busy,
  output logic                       drain_done,
  output logic                       overrun
);

  localparam int unsigned NBEATS = calc_nbeats(ROWS, COLS, BEAT_ELEMS);
  localparam logic [BEAT_AW-1:0] LAST_IDX = BEAT_AW'(NBEATS - 1);

  if (COLS % BEAT_ELEMS != 0) begin : g_bad_cols
    $error("ndp_result_drain: COLS must be a multiple of BEAT_ELEMS");
  end
  if ((64'd1 << BEAT_AW) < 64'(NBEATS)) begin : g_bad_aw
    $error("ndp_result_drain: BEAT_AW too narrow for NBEATS");
  end

  logic [1:0]                 r_state;
  logic [BEAT_AW-1:0]         r_cnt;
  logic                       r_done_q;
  logic                       r_overrun;
  logic [ROWS*COLS*WIDTH-1:0] r_snap;

  logic w_edge;
  logic w_valid;
  logic w_last;
  logic w_hs;

  assign w_edge  = calc_done_flag & ~r_done_q;
  assign w_valid = (r_state == S_DRAIN);
  assign w_last  = w_valid && (r_cnt == LAST_IDX);
  assign w_hs    = w_valid & drn.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_done_q  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done_q <= calc_done_flag;
      // Any edge outside IDLE (including DONE and the final-handshake cycle)
      // is dropped and only flagged.
      if (w_edge && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_hs) begin
            if (w_last) r_state <= S_DONE;
            else        r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Snapshot is deliberately not reset; it only loads on an accepted edge.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_IDLE) && w_edge) begin
      r_snap <= in_c;
    end
  end

  ndp_drain_beat_mux #(
    .WIDTH      (WIDTH),
    .BEAT_ELEMS (BEAT_ELEMS),
    .NBEATS     (NBEATS),
    .CNT_W      (BEAT_AW)
  ) u_mux (
    .i_snap (r_snap),
    .i_cnt  (r_cnt),
    .o_beat (drn.out_data)
  );

  assign drn.out_valid = w_valid;
  assign drn.out_addr  = r_cnt;
  assign drn.out_last  = w_last;
  assign busy          = w_valid;
  assign drain_done    = (r_state == S_DONE);
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_ndp_result_drain.sv
// Directed self-checking bench for ndp_result_drain (default geometry:
// 4x256 FP16 elements, 16 elements/beat, 64 beats).
module tb_ndp_result_drain;

  localparam int WIDTH = 16;
  localparam int ROWS  = 4;
  localparam int COLS  = 256;
  localparam int BE    = 16;
  localparam int AW    = 6;
  localparam int NB    = ROWS * COLS / BE;
  localparam int NELEM = ROWS * COLS;

  logic                       clk;
  logic                       reset;
  logic                       calc_done_flag;
  logic [ROWS*COLS*WIDTH-1:0] in_c;
  logic                       busy;
  logic                       drain_done;
  logic                       overrun;

  int n_pass  = 0;
  int n_total = 0;

  ndp_result_drain_if #(.WIDTH(WIDTH), .BEAT_ELEMS(BE), .BEAT_AW(AW)) u_if ();

  ndp_result_drain #(
    .WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .BEAT_ELEMS(BE), .BEAT_AW(AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .calc_done_flag (calc_done_flag),
    .in_c           (in_c),
    .drn            (u_if.master),
    .busy           (busy),
    .drain_done     (drain_done),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element value for a flat index; pattern 0 is r*256+c == flat index.
  function automatic logic [15:0] elem(input int pat, input int flat);
    logic [15:0] f;
    f = 16'(flat);
    case (pat)
      0: return f;
      1: return 16'h5000 | f;
      default: begin
        case (flat)
          0: return 16'hBC00;
          1: return 16'h8000;
          2: return 16'h3C00;
          3: return 16'hFE00;
          default: return (flat % 2 == 1) ? (16'h8000 | f) : f;
        endcase
      end
    endcase
  endfunction

  function automatic logic [15:0] exp_elem(input int pat, input int flat);
    logic [15:0] v;
    v = elem(pat, flat);
`ifdef NDP_DRAIN_RELU_EN
    if (v[15]) v = 16'h0000;
`endif
    return v;
  endfunction

  function automatic logic [BE*WIDTH-1:0] exp_beat(input int pat, input int idx);
    logic [BE*WIDTH-1:0] b;
    for (int e = 0; e < BE; e++) b[e*WIDTH +: WIDTH] = exp_elem(pat, idx * BE + e);
    return b;
  endfunction

  function automatic logic [ROWS*COLS*WIDTH-1:0] build_mat(input int pat);
    logic [ROWS*COLS*WIDTH-1:0] m;
    for (int f = 0; f < NELEM; f++) m[f*WIDTH +: WIDTH] = elem(pat, f);
    return m;
  endfunction

  // Raise calc_done_flag for one edge with matrix `pat`, sink not ready.
  task automatic pulse_done(input int pat);
    @(negedge clk);
    u_if.out_ready = 1'b0;
    in_c           = build_mat(pat);
    calc_done_flag = 1'b1;
    @(posedge clk);
    #1 calc_done_flag = 1'b0;
  endtask

  // Consume beats start..stop-1 of pattern `pat`; ready asserted with
  // probability pct%. Every cycle the presented beat must equal the next
  // expected beat, which also proves it holds still during stalls.
  task automatic run_beats(input int pat, input int pct, input int start, input int stop);
    int idx;
    int cyc;
    logic rdy;
    logic [BE*WIDTH-1:0] exp_d;
    logic exp_l;
    idx = start;
    cyc = 0;
    while (idx < stop && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      exp_d = exp_beat(pat, idx);
      exp_l = (idx == NB - 1);
      n_total++;
      if (u_if.out_valid !== 1'b1 || u_if.out_addr !== AW'(idx) || u_if.out_data !== exp_d
          || u_if.out_last !== exp_l || busy !== 1'b1) begin
        $display("FAIL beat%0d: valid=%b addr=%0d last=%b busy=%b data=%h ; required valid=1 addr=%0d last=%b busy=1 data=%h",
                 idx, u_if.out_valid, u_if.out_addr, u_if.out_last, busy, u_if.out_data,
                 idx, exp_l, exp_d);
      end else begin
        n_pass++;
      end
      rdy = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      u_if.out_ready = rdy;
      if (rdy) idx++;
    end
    if (idx < stop) begin
      n_total++;
      $display("FAIL beat_timeout: reached beat %0d, required %0d", idx, stop);
    end
  endtask

  // After the final accepted beat: one DONE cycle, then idle.
  task automatic finish_tile(input string tag);
    @(negedge clk);
    n_total++;
    if (drain_done !== 1'b1 || u_if.out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_done: drain_done=%b valid=%b busy=%b ; required 1 0 0",
               tag, drain_done, u_if.out_valid, busy);
    else n_pass++;
    u_if.out_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (drain_done !== 1'b0 || u_if.out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_idle: drain_done=%b valid=%b busy=%b ; required 0 0 0",
               tag, drain_done, u_if.out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    calc_done_flag = 1'b0;
    u_if.out_ready = 1'b0;
    in_c           = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if (u_if.out_valid !== 1'b0 || u_if.out_last !== 1'b0 || u_if.out_addr !== 6'd0
        || busy !== 1'b0 || drain_done !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_state: valid=%b last=%b addr=%0d busy=%b done=%b ovr=%b ; required all 0",
               u_if.out_valid, u_if.out_last, u_if.out_addr, busy, drain_done, overrun);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    pulse_done(0);
    run_beats(0, 100, 0, 17);
    @(negedge clk);
    u_if.out_ready = 1'b0;
    n_total++;
    if (u_if.out_addr !== 6'd17 || u_if.out_data[15:0] !== 16'h0110)
      $display("FAIL beat17_elem0: addr=%0d data=%h ; required addr=17 data=0110",
               u_if.out_addr, u_if.out_data[15:0]);
    else n_pass++;
    run_beats(0, 100, 17, NB);
    finish_tile("stream");
  endtask

  task automatic test_backpressure();
    pulse_done(0);
    run_beats(0, 30, 0, NB);
    finish_tile("bp");
  endtask

  task automatic test_overrun();
    pulse_done(0);
    run_beats(0, 100, 0, 20);
    in_c           = build_mat(1);
    calc_done_flag = 1'b1;
    @(posedge clk);
    #1 calc_done_flag = 1'b0;
    run_beats(0, 100, 20, NB);
    n_total++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: overrun=%b ; required 1", overrun);
    else n_pass++;
    finish_tile("ovr1");
    pulse_done(1);
    run_beats(1, 100, 0, NB);
    finish_tile("ovr2");
    n_total++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky: overrun=%b ; required 1", overrun);
    else n_pass++;
  endtask

  task automatic test_level_hold();
    int saw;
    @(negedge clk);
    u_if.out_ready = 1'b0;
    in_c           = build_mat(0);
    calc_done_flag = 1'b1;
    run_beats(0, 100, 0, NB);
    finish_tile("hold");
    saw = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (u_if.out_valid !== 1'b0 || drain_done !== 1'b0) saw++;
    end
    n_total++;
    if (saw !== 0) $display("FAIL level_hold_redrain: active_cycles=%0d ; required 0", saw);
    else n_pass++;
    calc_done_flag = 1'b0;
    @(negedge clk);
    pulse_done(1);
    run_beats(1, 100, 0, NB);
    finish_tile("hold2");
  endtask

  task automatic test_reset_mid();
    int saw;
    pulse_done(0);
    run_beats(0, 100, 0, 30);
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (u_if.out_valid !== 1'b0 || busy !== 1'b0 || drain_done !== 1'b0 || overrun !== 1'b0
        || u_if.out_last !== 1'b0 || u_if.out_addr !== 6'd0)
      $display("FAIL reset_mid: valid=%b busy=%b done=%b ovr=%b last=%b addr=%0d ; required all 0",
               u_if.out_valid, busy, drain_done, overrun, u_if.out_last, u_if.out_addr);
    else n_pass++;
    reset = 1'b0;
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (drain_done !== 1'b0 || u_if.out_valid !== 1'b0) saw++;
    end
    n_total++;
    if (saw !== 0) $display("FAIL reset_mid_quiet: active_cycles=%0d ; required 0", saw);
    else n_pass++;
    pulse_done(1);
    run_beats(1, 100, 0, NB);
    finish_tile("restart");
  endtask

  task automatic test_relu();
    logic [47:0] req;
`ifdef NDP_DRAIN_RELU_EN
    req = {16'h3C00, 16'h0000, 16'h0000};
`else
    req = {16'h3C00, 16'h8000, 16'hBC00};
`endif
    pulse_done(2);
    @(negedge clk);
    n_total++;
    if (u_if.out_valid !== 1'b1 || u_if.out_data[47:0] !== req)
      $display("FAIL relu_elems: valid=%b data=%h ; required valid=1 data=%h",
               u_if.out_valid, u_if.out_data[47:0], req);
    else n_pass++;
    run_beats(2, 100, 0, NB);
    finish_tile("relu");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_overrun();
    test_level_hold();
    test_reset_mid();
    test_relu();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
